// File: rtl/cpu_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_ctrl_pkg
// Purpose : Shared definitions for the CPU control unit. This package holds
//           the control_bus field positions, the bus and address ID values,
//           the opcodes, the sequencer states and the one-hot T-state
//           encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

  // control_bus field layout
  localparam int CB_AMID_EN_BIT = 0;
  localparam int CB_SID_EN_BIT  = 1;
  localparam int CB_MID_EN_BIT  = 2;
  localparam int CB_PC_INR_BIT  = 3;
  localparam int CB_AMID_LSB    = 4;
  localparam int CB_AMID_W      = 2;
  localparam int CB_SID_LSB     = 6;
  localparam int CB_MID_LSB     = 11;
  localparam int CB_ID_W        = 5;
  localparam int CB_ALU_LSB     = 16;
  localparam int CB_ALU_W       = 5;

  // Bus IDs (used for both MID and SID)
  localparam logic [4:0] ID_IR0 = 5'd0;
  localparam logic [4:0] ID_IR1 = 5'd1;
  localparam logic [4:0] ID_A   = 5'd2;
  localparam logic [4:0] ID_B   = 5'd3;
  localparam logic [4:0] ID_MEM = 5'd4;
  localparam logic [4:0] ID_R0  = 5'd5;
  localparam logic [4:0] ID_R1  = 5'd6;
  localparam logic [4:0] ID_PC0 = 5'd9;
  localparam logic [4:0] ID_PC1 = 5'd10;
  localparam logic [4:0] ID_ALU = 5'd18;

  // Address-source IDs
  localparam logic [1:0] AMID_PC   = 2'd0;
  localparam logic [1:0] AMID_R1R0 = 2'd3;

  // Opcodes held in IR0[7:5]
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ALU = 3'd2;
  localparam logic [2:0] OP_LDI = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;
  localparam logic [2:0] OP_JCC = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH0 = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_EXEC0  = 3'd2,
    ST_EXEC1  = 3'd3,
    ST_PAUSED = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  // The idle states (PAUSED and HALTED) show no T-state.
  function automatic logic [3:0] t_onehot(input state_e s);
    case (s)
      ST_FETCH0: t_onehot = 4'b0001;
      ST_FETCH1: t_onehot = 4'b0010;
      ST_EXEC0:  t_onehot = 4'b0100;
      ST_EXEC1:  t_onehot = 4'b1000;
      default:   t_onehot = 4'b0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : cpu_control_unit_if
// Purpose : Connects the control unit to the datapath.
// Signals : hlt, instr_data[15:0] ({IR1,IR0}) and status[3:0] go into the
//           control unit. control_bus[CB_WIDTH-1:0], T[3:0] and halted come
//           out of it.
// Modports: master = control unit (drives control_bus, T and halted)
//           slave  = datapath side
// Rev     : 1.0  initial release
// ============================================================================
interface cpu_control_unit_if #(
  parameter int CB_WIDTH = 33
);
  logic                hlt;
  logic [15:0]         instr_data;
  logic [3:0]          status;
  logic [CB_WIDTH-1:0] control_bus;
  logic [3:0]          T;
  logic                halted;

  modport master (input hlt, input instr_data, input status,
                  output control_bus, output T, output halted);
  modport slave  (output hlt, output instr_data, output status,
                  input control_bus, input T, input halted);
endinterface
`default_nettype wire

// File: rtl/cpu_control_unit_ctrl_word_pack.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_word_pack
// Purpose : Combinational packer. It places the enables, AMID, SID, MID and
//           ALU opcode fields into the control word. Bits above the ALU
//           field are driven to 0.
// Ports   : amid_en_i, sid_en_i, mid_en_i, pc_inr_i  - single-bit enables
//           amid_i[1:0], sid_i[4:0], mid_i[4:0], alu_op_i[4:0] - fields
//           word_o[CB_WIDTH-1:0] - packed control word
// Rev     : 1.0  initial release
// ============================================================================
module ctrl_word_pack
  import cpu_ctrl_pkg::*;
#(
  parameter int CB_WIDTH = 33
) (
  input  logic                amid_en_i,
  input  logic                sid_en_i,
  input  logic                mid_en_i,
  input  logic                pc_inr_i,
  input  logic [1:0]          amid_i,
  input  logic [4:0]          sid_i,
  input  logic [4:0]          mid_i,
  input  logic [4:0]          alu_op_i,
  output logic [CB_WIDTH-1:0] word_o
);

  always_comb begin
    word_o                                = '0;
    word_o[CB_AMID_EN_BIT]                = amid_en_i;
    word_o[CB_SID_EN_BIT]                 = sid_en_i;
    word_o[CB_MID_EN_BIT]                 = mid_en_i;
    word_o[CB_PC_INR_BIT]                 = pc_inr_i;
    word_o[CB_AMID_LSB +: CB_AMID_W]      = amid_i;
    word_o[CB_SID_LSB  +: CB_ID_W]        = sid_i;
    word_o[CB_MID_LSB  +: CB_ID_W]        = mid_i;
    word_o[CB_ALU_LSB  +: CB_ALU_W]       = alu_op_i;
  end

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : cpu_control_unit
// Purpose : Micro-sequencer. It fetches a 2-byte instruction, decodes it and
//           issues one control word per T-state (T0..T3).
// Ports   : clk   - system clock
//           reset - synchronous active-high reset
//           bus   - cpu_control_unit_if.master (hlt, instr_data, status in;
//                   control_bus, T, halted out)
// Rev     : 1.0  initial release
// ============================================================================
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int CB_WIDTH       = 33,
  parameter bit FETCH_PAUSE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  cpu_control_unit_if.master bus
);

  state_e     state_q, state_d;
  logic [3:0] t_q;
  logic       halted_q;

  logic [2:0] op;
  logic [4:0] f0, f1;
  logic [3:0] cond_mask;
  logic       jcc_taken;
  logic       pause_req;
  logic       unused_ir1_hi;

  logic       amid_en, sid_en, mid_en, pc_inr;
  logic [1:0] amid;
  logic [4:0] sid, mid, alu_op;

  assign op            = bus.instr_data[7:5];
  assign f0            = bus.instr_data[4:0];
  assign f1            = bus.instr_data[12:8];
  assign cond_mask     = bus.instr_data[11:8];
  assign unused_ir1_hi = ^bus.instr_data[15:13];

  // An empty condition mask makes the jump unconditional.
  assign jcc_taken = (cond_mask == 4'd0) || ((bus.status & cond_mask) != 4'd0);
  assign pause_req = FETCH_PAUSE_EN && bus.hlt;

  // Field decode. Reset forces every field to 0, so the bus is quiet
  // while reset is held.
  always_comb begin
    amid_en = 1'b0;
    sid_en  = 1'b0;
    mid_en  = 1'b0;
    pc_inr  = 1'b0;
    amid    = AMID_PC;
    sid     = 5'd0;
    mid     = 5'd0;
    alu_op  = 5'd0;
    if (!reset) begin
      case (state_q)
        ST_FETCH0, ST_FETCH1: begin
          amid_en = 1'b1;
          sid_en  = 1'b1;
          mid_en  = 1'b1;
          pc_inr  = 1'b1;
          amid    = AMID_PC;
          mid     = ID_MEM;
          sid     = (state_q == ST_FETCH0) ? ID_IR0 : ID_IR1;
        end
        ST_EXEC0: begin
          case (op)
            OP_MOV: begin
              mid_en = 1'b1; sid_en = 1'b1; mid = f0; sid = f1;
            end
            OP_ALU: begin
              mid_en = 1'b1; sid_en = 1'b1; alu_op = f0; mid = ID_ALU; sid = f1;
            end
            OP_LDI: begin
              mid_en = 1'b1; sid_en = 1'b1; mid = ID_IR1; sid = f0;
            end
            OP_LD: begin
              amid_en = 1'b1; mid_en = 1'b1; sid_en = 1'b1;
              amid = AMID_R1R0; mid = ID_MEM; sid = f0;
            end
            OP_ST: begin
              amid_en = 1'b1; mid_en = 1'b1; sid_en = 1'b1;
              amid = AMID_R1R0; mid = f0; sid = ID_MEM;
            end
            OP_JCC: begin
              if (jcc_taken) begin
                mid_en = 1'b1; sid_en = 1'b1; mid = ID_R0; sid = ID_PC0;
              end
            end
            default: ; // NOP and HLT drive nothing
          endcase
        end
        // EXEC1 is reached only by a taken JCC.
        ST_EXEC1: begin
          mid_en = 1'b1; sid_en = 1'b1; mid = ID_R1; sid = ID_PC1;
        end
        default: ;
      endcase
    end
  end

  // Next state. hlt is examined only at the instruction boundary, so an
  // instruction that has started always runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH0: state_d = ST_FETCH1;
      ST_FETCH1: state_d = ST_EXEC0;
      ST_EXEC0: begin
        if (op == OP_HLT)                    state_d = ST_HALTED;
        else if (op == OP_JCC && jcc_taken)  state_d = ST_EXEC1;
        else if (pause_req)                  state_d = ST_PAUSED;
        else                                 state_d = ST_FETCH0;
      end
      ST_EXEC1:  state_d = pause_req ? ST_PAUSED : ST_FETCH0;
      ST_PAUSED: state_d = pause_req ? ST_PAUSED : ST_FETCH0;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH0;
    endcase
  end

  // T and halted are registered together with the state, from the
  // next-state value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH0;
      t_q      <= t_onehot(ST_FETCH0);
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_onehot(state_d);
      halted_q <= (state_d == ST_HALTED);
    end
  end

  assign bus.T      = reset ? 4'd0 : t_q;
  assign bus.halted = reset ? 1'b0 : halted_q;

  ctrl_word_pack #(.CB_WIDTH(CB_WIDTH)) u_pack (
    .amid_en_i (amid_en),
    .sid_en_i  (sid_en),
    .mid_en_i  (mid_en),
    .pc_inr_i  (pc_inr),
    .amid_i    (amid),
    .sid_i     (sid),
    .mid_i     (mid),
    .alu_op_i  (alu_op),
    .word_o    (bus.control_bus)
  );

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_control_unit
// Purpose : Self-checking bench for cpu_control_unit. Each step pushes the
//           expected control word, T and halted values onto a scoreboard.
//           The entry is popped and compared at the following falling edge.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cpu_control_unit;

  logic clk;
  logic reset;

  typedef struct {
    logic [32:0] cb;
    logic [3:0]  t;
    logic        h;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  cpu_control_unit_if #(.CB_WIDTH(33)) bus ();

  cpu_control_unit #(.CB_WIDTH(33), .FETCH_PAUSE_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Call shortly after a rising edge. The check happens at the next
  // falling edge, and the task returns 1 ns after the next rising edge.
  task automatic cyc(input logic [32:0] cb, input logic [3:0] t,
                     input logic h, input string tag);
    exp_t e;
    exp_t got;
    e.cb = cb; e.t = t; e.h = h; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    compared++;
    assert (bus.control_bus === got.cb) else begin
      mismatched++;
      $error("FAIL %s control_bus observed=%h expected=%h", got.tag, bus.control_bus, got.cb);
    end
    compared++;
    assert (bus.T === got.t) else begin
      mismatched++;
      $error("FAIL %s T observed=%b expected=%b", got.tag, bus.T, got.t);
    end
    compared++;
    assert (bus.halted === got.h) else begin
      mismatched++;
      $error("FAIL %s halted observed=%b expected=%b", got.tag, bus.halted, got.h);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    cyc(33'h0000200F, 4'b0001, 1'b0, "t0");
    cyc(33'h0000204F, 4'b0010, 1'b0, "t1");
  endtask

  initial begin
    reset          = 1'b1;
    bus.hlt        = 1'b0;
    bus.instr_data = 16'h0000;
    bus.status     = 4'h0;
    @(posedge clk);
    #1;
    cyc(33'h0, 4'b0000, 1'b0, "rst_a");
    cyc(33'h0, 4'b0000, 1'b0, "rst_b");
    reset = 1'b0;

    // MOV A->B; the instruction is 3 cycles long, so T0 follows directly
    fetch();
    bus.instr_data = 16'h0322;
    cyc(33'h000010C6, 4'b0100, 1'b0, "mov_t2");
    // ALU op 3 -> A
    fetch();
    bus.instr_data = 16'h0243;
    cyc(33'h00039086, 4'b0100, 1'b0, "alu_t2");
    // LDI into R0 (f0=5)
    fetch();
    bus.instr_data = 16'h0765;
    cyc(33'h00000946, 4'b0100, 1'b0, "ldi_t2");
    // LD A from [R1R0]
    fetch();
    bus.instr_data = 16'h0082;
    cyc(33'h000020B7, 4'b0100, 1'b0, "ld_t2");
    // ST B to [R1R0]
    fetch();
    bus.instr_data = 16'h00A3;
    cyc(33'h00001937, 4'b0100, 1'b0, "st_t2");
    // JCC taken (mask 1, status 1)
    fetch();
    bus.instr_data = 16'h01C0;
    bus.status     = 4'h1;
    cyc(33'h00002A46, 4'b0100, 1'b0, "jcc_t2");
    cyc(33'h00003286, 4'b1000, 1'b0, "jcc_t3");
    // JCC not taken: no enables and no T3
    fetch();
    bus.status = 4'h0;
    cyc(33'h0, 4'b0100, 1'b0, "jcc_nt_t2");
    // JCC with an empty mask is always taken
    fetch();
    bus.instr_data = 16'h00C0;
    cyc(33'h00002A46, 4'b0100, 1'b0, "jcc_uncond_t2");
    cyc(33'h00003286, 4'b1000, 1'b0, "jcc_uncond_t3");
    // JCC mask 0x6 against status 0x4 is taken
    fetch();
    bus.instr_data = 16'h06C0;
    bus.status     = 4'h4;
    cyc(33'h00002A46, 4'b0100, 1'b0, "jcc_mask_t2");
    cyc(33'h00003286, 4'b1000, 1'b0, "jcc_mask_t3");

    // hlt raised in T1: the NOP completes, then the sequencer pauses
    cyc(33'h0000200F, 4'b0001, 1'b0, "pre_hlt_t0");
    bus.hlt        = 1'b1;
    bus.instr_data = 16'h0000;
    cyc(33'h0000204F, 4'b0010, 1'b0, "hlt_t1");
    cyc(33'h0, 4'b0100, 1'b0, "hlt_nop_t2");
    cyc(33'h0, 4'b0000, 1'b0, "paused_a");
    cyc(33'h0, 4'b0000, 1'b0, "paused_b");
    bus.hlt = 1'b0;
    cyc(33'h0, 4'b0000, 1'b0, "paused_rel");
    fetch();

    // HLT instruction: halted until reset, and hlt has no effect
    bus.instr_data = 16'h00E0;
    cyc(33'h0, 4'b0100, 1'b0, "hlt_op_t2");
    cyc(33'h0, 4'b0000, 1'b1, "halted_a");
    bus.hlt = 1'b1;
    cyc(33'h0, 4'b0000, 1'b1, "halted_b");
    bus.hlt = 1'b0;
    cyc(33'h0, 4'b0000, 1'b1, "halted_c");
    reset = 1'b1;
    cyc(33'h0, 4'b0000, 1'b0, "halted_rst");
    reset = 1'b0;
    cyc(33'h0000200F, 4'b0001, 1'b0, "restart_t0");
    // Reset during T1 aborts the instruction before any EXEC cycle
    reset = 1'b1;
    cyc(33'h0, 4'b0000, 1'b0, "rst_in_t1");
    reset = 1'b0;
    cyc(33'h0000200F, 4'b0001, 1'b0, "abort_t0");
    cyc(33'h0000204F, 4'b0010, 1'b0, "abort_t1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
